// File: rtl/sample_readback.sv
// Read-back engine: walks an address window through the memory controller's read port,
// then streams the returned words through a FIFO or checks them against an address pattern.
module sample_readback #(
  parameter int ADDR_WIDTH      = 23,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ERR_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  check_mode,
  input  logic                  mem_busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_valid,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_data_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] req_addr, rsp_addr;
  logic [ADDR_WIDTH:0]   req_left;
  logic                  mode;
  logic [CW-1:0]         in_flight, fifo_cnt;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [MAX_OUTSTANDING];
  logic [CW:0]           occupancy;
  logic                  credit_ok, start_acc, req_fire, rsp_acc;
  logic                  fifo_wr, fifo_rd, mismatch;

  function automatic logic [DATA_WIDTH-1:0] addr_pattern(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH+ADDR_WIDTH-1:0] ext;
    ext = {{DATA_WIDTH{1'b0}}, a};
    return ext[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Words in flight and words parked in the FIFO share one credit pool,
  // so the FIFO can never be overrun by returning data.
  assign occupancy    = {1'b0, in_flight} + {1'b0, fifo_cnt};
  assign credit_ok    = occupancy < {1'b0, MAX_C};
  assign start_acc    = (state == IDLE) && start && (word_count != '0);
  assign mem_rd_valid = (state == ISSUE) && credit_ok && !mem_busy;
  assign req_fire     = mem_rd_valid;
  // After a mid-sweep reset in_flight is 0, so stale returns fall through here.
  assign rsp_acc      = mem_data_valid && (in_flight != '0);
  assign mismatch     = mem_data != addr_pattern(rsp_addr);
  assign out_valid    = fifo_cnt != '0;
  assign fifo_rd      = out_valid && out_ready;
  assign fifo_wr      = rsp_acc && !mode && ((fifo_cnt != MAX_C) || fifo_rd);
  assign out_data     = out_valid ? fifo_mem[rd_ptr] : '0;
  assign mem_addr     = req_addr;
  assign busy         = (state == ISSUE) || (state == DRAIN);
  assign done         = state == DONE;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start && word_count == '0) state_nxt = DONE;
             else if (start_acc)            state_nxt = ISSUE;
      ISSUE: if (req_fire && req_left == (ADDR_WIDTH+1)'(1)) state_nxt = DRAIN;
      DRAIN: if (in_flight == '0 && fifo_cnt == '0) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      req_addr       <= '0;
      rsp_addr       <= '0;
      req_left       <= '0;
      mode           <= 1'b0;
      in_flight      <= '0;
      fifo_cnt       <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        req_addr       <= base_addr;
        rsp_addr       <= base_addr;
        req_left       <= word_count;
        mode           <= check_mode;
        err_count      <= '0;
        first_err_addr <= '0;
      end else begin
        if (req_fire) begin
          req_addr <= req_addr + 1'b1;
          req_left <= req_left - 1'b1;
        end
        if (rsp_acc) begin
          rsp_addr <= rsp_addr + 1'b1;
          if (mode && mismatch) begin
            err_count <= sat_inc(err_count);
            if (err_count == '0) first_err_addr <= rsp_addr;
          end
        end
      end

      if (req_fire && !rsp_acc)      in_flight <= in_flight + 1'b1;
      else if (!req_fire && rsp_acc) in_flight <= in_flight - 1'b1;

      if (fifo_wr && !fifo_rd)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!fifo_wr && fifo_rd) fifo_cnt <= fifo_cnt - 1'b1;
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage is data only; validity lives entirely in fifo_cnt.
  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= mem_data;
  end

endmodule

// File: tb/tb_sample_readback.sv
// Directed bench for sample_readback: 2-cycle-latency memory model, sweep monitor,
// and a second instance with a 2-bit error counter for saturation.
module tb_sample_readback;
  localparam int AW = 23;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          check_mode = 1'b0;
  logic          mem_busy = 1'b0;
  logic [DW-1:0] mem_data = '0;
  logic          mem_data_valid = 1'b0;
  logic          out_ready = 1'b1;

  logic [AW-1:0] mem_addr, first_err_addr;
  logic          mem_rd_valid, out_valid, busy, done;
  logic [DW-1:0] out_data;
  logic [15:0]   err_count;

  logic [AW-1:0] s_mem_addr, s_first_err_addr;
  logic          s_mem_rd_valid, s_out_valid, s_busy, s_done;
  logic [DW-1:0] s_out_data;
  logic [1:0]    s_err_count;

  sample_readback #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4), .ERR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .check_mode(check_mode), .mem_busy(mem_busy), .mem_addr(mem_addr), .mem_rd_valid(mem_rd_valid),
    .mem_data(mem_data), .mem_data_valid(mem_data_valid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .err_count(err_count),
    .first_err_addr(first_err_addr));

  sample_readback #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4), .ERR_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .check_mode(check_mode), .mem_busy(mem_busy), .mem_addr(s_mem_addr), .mem_rd_valid(s_mem_rd_valid),
    .mem_data(mem_data), .mem_data_valid(mem_data_valid), .out_data(s_out_data), .out_valid(s_out_valid),
    .out_ready(out_ready), .busy(s_busy), .done(s_done), .err_count(s_err_count),
    .first_err_addr(s_first_err_addr));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory content: the address pattern, corrupted at addresses listed in bad_map.
  int bad_map[int];
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    w = {9'b0, a};
    if (bad_map.exists(int'(a))) w = w ^ 32'hDEAD_0000;
    return w;
  endfunction

  // 2-cycle read latency: request seen in cycle c returns in cycle c+2.
  logic          st0_v = 1'b0, st1_v = 1'b0;
  logic [AW-1:0] st0_a = '0, st1_a = '0;
  always @(negedge clk) begin
    mem_data_valid = st1_v;
    mem_data       = mem_word(st1_a);
    st1_v = st0_v;
    st1_a = st0_a;
    st0_v = mem_rd_valid;
    st0_a = mem_addr;
  end

  logic [AW-1:0] req_log[$];
  logic [DW-1:0] got[$];
  int reqs, pops, max_occ, ov_seen, done_cnt, stall_cycles, rd_in_stall, addr_moved;
  logic [AW-1:0] stall_addr0;

  always @(negedge clk) begin
    if (mem_rd_valid) begin
      reqs++;
      if (reqs - pops > max_occ) max_occ = reqs - pops;
      req_log.push_back(mem_addr);
    end
    if (out_valid) ov_seen++;
    if (out_valid && out_ready) begin
      got.push_back(out_data);
      pops++;
    end
    if (done) done_cnt++;
    if (mem_busy) begin
      stall_cycles++;
      if (mem_rd_valid) rd_in_stall++;
      if (stall_cycles == 1) stall_addr0 = mem_addr;
      else if (mem_addr != stall_addr0) addr_moved++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    req_log.delete();
    got.delete();
    reqs = 0; pops = 0; max_occ = 0; ov_seen = 0; done_cnt = 0;
    stall_cycles = 0; rd_in_stall = 0; addr_moved = 0;
  endtask

  task automatic run_sweep(input logic [AW-1:0] b, input logic [AW:0] n, input bit cm,
                           input bit bp, input bit stall, input bit extra_start);
    int cyc, stall_left;
    bit stall_done;
    clear_mon();
    base_addr = b; word_count = n; check_mode = cm; start = 1'b1;
    tick();
    start = 1'b0; base_addr = '0; word_count = '0; check_mode = ~cm;
    cyc = 0; stall_left = 0; stall_done = 0;
    while (done_cnt == 0 && cyc < 400) begin
      out_ready = bp ? (cyc % 4 == 0) : 1'b1;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) mem_busy = 1'b0;
      end
      if (stall && !stall_done && req_log.size() >= 3) begin
        mem_busy = 1'b1; stall_left = 5; stall_done = 1;
      end
      if (extra_start && cyc == 2) begin
        start = 1'b1; base_addr = 23'h300; word_count = 24'd3;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0; out_ready = 1'b1; mem_busy = 1'b0;
    check("sweep_done_seen", done_cnt != 0, 1'b1);
  endtask

  initial begin
    int cyc;
    logic [AW-1:0] wrap_tbl [4];
    wrap_tbl = '{23'h7FFFFE, 23'h7FFFFF, 23'h000000, 23'h000001};

    clear_mon();
    repeat (3) tick();
    check("rst_mem_rd_valid", mem_rd_valid, 1'b0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err_count", err_count, 0);
    check("rst_first_err", first_err_addr, 0);
    rst = 1'b0;
    tick();

    // Check mode, clean memory
    run_sweep(23'h10, 24'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    check("clean_reqs", reqs, 8);
    for (int i = 0; i < 8 && i < req_log.size(); i++)
      check($sformatf("clean_addr%0d", i), req_log[i], 23'h10 + i);
    check("clean_err", err_count, 0);
    check("clean_no_out_valid", ov_seen, 0);
    check("clean_done_pulses", done_cnt, 1);
    check("clean_busy_after", busy, 1'b0);

    // Check mode, two injected errors
    bad_map[32'h13] = 1; bad_map[32'h15] = 1;
    run_sweep(23'h10, 24'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    check("err2_count", err_count, 2);
    check("err2_first", first_err_addr, 23'h13);
    check("err2_count_w2", s_err_count, 2);
    bad_map.delete();

    // Five errors: wide counter counts, 2-bit counter saturates
    bad_map[32'h21] = 1; bad_map[32'h22] = 1; bad_map[32'h24] = 1;
    bad_map[32'h26] = 1; bad_map[32'h27] = 1;
    run_sweep(23'h20, 24'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    check("err5_count", err_count, 5);
    check("err5_first", first_err_addr, 23'h21);
    check("err5_sat_w2", s_err_count, 3);
    check("err5_first_w2", s_first_err_addr, 23'h21);
    bad_map.delete();

    // Stream mode with 1-of-4 backpressure; 0x105 corrupted to expose any check leak
    bad_map[32'h105] = 1;
    run_sweep(23'h100, 24'd16, 1'b0, 1'b1, 1'b0, 1'b0);
    check("stream_reqs", reqs, 16);
    check("stream_words", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++)
      check($sformatf("stream_word%0d", i), got[i], (i == 5) ? 32'hDEAD_0105 : 32'h100 + i);
    check("stream_max_occ", max_occ, 4);
    check("stream_err", err_count, 0);
    bad_map.delete();

    // Address wrap
    run_sweep(23'h7FFFFE, 24'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    check("wrap_reqs", reqs, 4);
    for (int i = 0; i < 4 && i < req_log.size(); i++)
      check($sformatf("wrap_addr%0d", i), req_log[i], wrap_tbl[i]);
    check("wrap_err", err_count, 0);

    // mem_busy stall for 5 cycles mid-sweep
    run_sweep(23'h40, 24'd10, 1'b1, 1'b0, 1'b1, 1'b0);
    check("stall_cycles", stall_cycles, 5);
    check("stall_no_req", rd_in_stall, 0);
    check("stall_addr_stable", addr_moved, 0);
    check("stall_reqs", reqs, 10);
    for (int i = 0; i < 10 && i < req_log.size(); i++)
      check($sformatf("stall_addr%0d", i), req_log[i], 23'h40 + i);
    check("stall_err", err_count, 0);

    // Zero-length sweep
    clear_mon();
    word_count = '0; base_addr = 23'h77; check_mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    tick();
    check("zero_done_pulse", done, 1'b0);
    check("zero_reqs", reqs, 0);

    // Start while busy is ignored
    run_sweep(23'h200, 24'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    check("ignst_reqs", reqs, 6);
    if (req_log.size() > 0) check("ignst_last", req_log[req_log.size()-1], 23'h205);
    check("ignst_done_pulses", done_cnt, 1);
    check("ignst_err", err_count, 0);

    // Reset mid-sweep, stream mode, with words still returning
    clear_mon();
    base_addr = 23'h50; word_count = 24'd10; check_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (reqs < 3 && cyc < 50) begin
      tick();
      cyc++;
    end
    check("rstmid_reached", reqs >= 3, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_rd_valid", mem_rd_valid, 1'b0);
    check("rstmid_out_valid", out_valid, 1'b0);
    check("rstmid_mem_addr", mem_addr, 0);
    check("rstmid_err", err_count, 0);
    clear_mon();
    repeat (6) tick();
    check("rstmid_no_stream", ov_seen, 0);
    check("rstmid_no_reqs", reqs, 0);
    check("rstmid_no_done", done_cnt, 0);
    run_sweep(23'h60, 24'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("after_rst_reqs", reqs, 5);
    if (req_log.size() > 0) check("after_rst_first", req_log[0], 23'h60);
    check("after_rst_err", err_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
